// File: rtl/nhc_pkg.sv
// Shared types and constants for the network homeostasis controller.
package nhc_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        MEAN  = 2'd1,
        DRIVE = 2'd2
    } nhc_state_e;

    localparam int NHC_RATE_W = 16;
    localparam int NHC_DA_W   = 8;

    // dbg_status = {state, upd_cnt, dopamine, mean}
    localparam int DBG_MEAN_LSB = 0;
    localparam int DBG_MEAN_W   = 16;
    localparam int DBG_DA_LSB   = 16;
    localparam int DBG_DA_W     = 8;
    localparam int DBG_UPD_LSB  = 24;
    localparam int DBG_UPD_W    = 6;
    localparam int DBG_ST_LSB   = 30;
    localparam int DBG_ST_W     = 2;

endpackage

// File: rtl/spike_rate_lp.sv
// Per-neuron low-pass spike-rate estimator:
// rate += alpha/256 * (spike ? full_scale : 0) - alpha/256 * rate, saturating.
module spike_rate_lp #(
    parameter int RATE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              spike,
    input  logic [7:0]        alpha,
    output logic [RATE_W-1:0] rate
);

    localparam int W = RATE_W + 2;

    logic [RATE_W+7:0] prod;
    logic [RATE_W-1:0] decay;
    logic [W-1:0]      gain;
    logic [W-1:0]      sum;
    logic [RATE_W-1:0] rate_nx;

    always_comb begin
        prod  = (RATE_W+8)'(rate) * (RATE_W+8)'(alpha);
        decay = RATE_W'(prod >> 8);
        gain  = spike ? (W'(alpha) << (RATE_W - 8)) : '0;
        sum   = W'(rate) - W'(decay) + gain;
        // only the top end can exceed range: decay never exceeds rate
        rate_nx = (sum[W-1:RATE_W] != '0) ? '1 : sum[RATE_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rate <= '0;
        else if (clk_en) rate <= rate_nx;
    end

endmodule

// File: rtl/network_homeostasis_ctrl.sv
// Network rate homeostasis: per-neuron LP rates, beat-serial mean, proportional dopamine drive.
// Define NHC_SLEW_LIMIT_EN to limit each dopamine update to SLEW_STEP.
module network_homeostasis_ctrl
    import nhc_pkg::*;
#(
    parameter int N_NEURON  = 64,
    parameter int LANES     = 8,
    parameter int RATE_W    = NHC_RATE_W,
    parameter int DA_W      = NHC_DA_W,
    parameter int DA_MID    = 128,
    parameter int SLEW_STEP = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic [N_NEURON-1:0] spike_in,
    input  logic [7:0]          alpha_u8_i,
    input  logic [RATE_W-1:0]   target_i,
    input  logic [RATE_W-1:0]   hyst_i,
    input  logic [3:0]          kp_shift_i,
    input  logic [DA_W-1:0]     da_min_i,
    input  logic [DA_W-1:0]     da_max_i,
    output logic [RATE_W-1:0]   rate_bus_o [N_NEURON],
    output logic [RATE_W-1:0]   mean_o,
    output logic                mean_valid_o,
    output logic [DA_W-1:0]     dopamine_o,
    output logic [31:0]         dbg_status
);

    localparam int BEATS  = N_NEURON / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NSH    = $clog2(N_NEURON);
    localparam int ACC_W  = RATE_W + NSH;
    localparam int SW     = RATE_W + DA_W + 2;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

`ifdef NHC_SLEW_LIMIT_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif
    // A step of 2^DA_W can never bind, so the unslewed build shares the datapath.
    localparam logic signed [SW-1:0] STEP = SW'(SLEW_EN ? SLEW_STEP : (1 << DA_W));

    nhc_state_e              state, state_nx;
    logic [BEAT_W-1:0]       beat;
    logic [ACC_W-1:0]        acc, lane_sum;
    logic [RATE_W-1:0]       mean_calc, mean_c;
    logic signed [RATE_W:0]  err_r, corr;
    logic [RATE_W-1:0]       err_abs;
    logic signed [SW-1:0]    demand, delta, slewed;
    logic [DA_W-1:0]         da_tgt, da_nx;
    logic [5:0]              upd_cnt;
    logic                    valid_q;
    logic [31:0]             dbg_nx;

    for (genvar i = 0; i < N_NEURON; i++) begin : G_RATE
        spike_rate_lp #(.RATE_W(RATE_W)) u_lp (
            .clk    (clk),
            .rst    (rst),
            .clk_en (clk_en),
            .spike  (spike_in[i]),
            .alpha  (alpha_u8_i),
            .rate   (rate_bus_o[i])
        );
    end

    function automatic logic [DA_W-1:0] clamp_da(input logic signed [SW-1:0] v,
                                                 input logic [DA_W-1:0] lo,
                                                 input logic [DA_W-1:0] hi);
        logic signed [SW-1:0] r;
        r = v;
        if (r > $signed(SW'(hi))) r = $signed(SW'(hi));
        // lower bound applied last so da_min wins when the limits cross
        if (r < $signed(SW'(lo))) r = $signed(SW'(lo));
        return DA_W'(r);
    endfunction

    always_comb begin : p_lane_sum
        logic [NSH-1:0] idx;
        idx      = '0;
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            idx      = NSH'(int'(beat) * LANES + l);
            lane_sum = lane_sum + ACC_W'(rate_bus_o[idx]);
        end
    end

    assign mean_calc = RATE_W'(acc >> NSH);

    always_comb begin
        err_abs = err_r[RATE_W] ? RATE_W'(-err_r) : RATE_W'(err_r);
        corr    = err_r >>> kp_shift_i;
        demand  = SW'(DA_MID) + SW'(corr);
        da_tgt  = clamp_da(demand, da_min_i, da_max_i);
        delta   = SW'(da_tgt) - SW'(dopamine_o);
        slewed  = SW'(da_tgt);
        if (delta > STEP)       slewed = SW'(dopamine_o) + STEP;
        else if (delta < -STEP) slewed = SW'(dopamine_o) - STEP;
        da_nx = (err_abs <= hyst_i) ? dopamine_o : clamp_da(slewed, da_min_i, da_max_i);
    end

    always_comb begin
        state_nx = state;
        case (state)
            ACCUM:   if (beat == BEAT_LAST) state_nx = MEAN;
            MEAN:    state_nx = DRIVE;
            DRIVE:   state_nx = ACCUM;
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         state <= ACCUM;
        else if (clk_en) state <= state_nx;
    end

    always_comb begin
        dbg_nx = '0;
        dbg_nx[DBG_ST_LSB   +: DBG_ST_W]   = state;
        dbg_nx[DBG_UPD_LSB  +: DBG_UPD_W]  = upd_cnt;
        dbg_nx[DBG_DA_LSB   +: DBG_DA_W]   = DBG_DA_W'(dopamine_o);
        dbg_nx[DBG_MEAN_LSB +: DBG_MEAN_W] = DBG_MEAN_W'(mean_o);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat       <= '0;
            acc        <= '0;
            mean_c     <= '0;
            err_r      <= '0;
            mean_o     <= '0;
            valid_q    <= 1'b0;
            dopamine_o <= DA_W'(DA_MID);
            upd_cnt    <= '0;
            dbg_status <= '0;
        end else if (clk_en) begin
            valid_q    <= 1'b0;
            dbg_status <= dbg_nx;
            case (state)
                ACCUM: begin
                    acc  <= (beat == '0) ? lane_sum : acc + lane_sum;
                    beat <= (beat == BEAT_LAST) ? '0 : beat + 1'b1;
                end
                MEAN: begin
                    mean_c <= mean_calc;
                    err_r  <= $signed({1'b0, target_i}) - $signed({1'b0, mean_calc});
                end
                DRIVE: begin
                    mean_o     <= mean_c;
                    dopamine_o <= da_nx;
                    valid_q    <= 1'b1;
                    upd_cnt    <= upd_cnt + 1'b1;
                end
                default: ;
            endcase
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign mean_valid_o = valid_q & clk_en;

endmodule

// File: tb/tb_network_homeostasis_ctrl.sv
// Directed bench for network_homeostasis_ctrl (N_NEURON=8, LANES=4); honours NHC_SLEW_LIMIT_EN.
module tb_network_homeostasis_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic [7:0]  spike_in = '0;
  logic [7:0]  alpha = '0;
  logic [15:0] target = 16'd4096;
  logic [15:0] hyst = 16'd256;
  logic [3:0]  kp = 4'd4;
  logic [7:0]  da_min = 8'd0;
  logic [7:0]  da_max = 8'd255;
  logic [15:0] rate_bus [8];
  logic [15:0] mean;
  logic        valid;
  logic [7:0]  dop;
  logic [31:0] dbg;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  network_homeostasis_ctrl #(
    .N_NEURON(8), .LANES(4), .RATE_W(16), .DA_W(8), .DA_MID(128), .SLEW_STEP(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .spike_in     (spike_in),
    .alpha_u8_i   (alpha),
    .target_i     (target),
    .hyst_i       (hyst),
    .kp_shift_i   (kp),
    .da_min_i     (da_min),
    .da_max_i     (da_max),
    .rate_bus_o   (rate_bus),
    .mean_o       (mean),
    .mean_valid_o (valid),
    .dopamine_o   (dop),
    .dbg_status   (dbg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int n);
    logic got;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        step();
        if (valid) got = 1'b1;
      end
      checks++;
      if (got !== 1'b1) begin errs++; $error("FAIL pulse_timeout: observed=%0d", got); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    checks++; if (dop !== 8'd128) begin errs++; $error("FAIL rst_dop: observed=%0d", dop); end
    checks++; if (mean !== 16'd0) begin errs++; $error("FAIL rst_mean: observed=%0d", mean); end
    checks++; if (valid !== 1'b0) begin errs++; $error("FAIL rst_valid: observed=%0d", valid); end
    checks++; if (dbg !== 32'd0) begin errs++; $error("FAIL rst_dbg: observed=%0d", dbg); end

    rst = 1'b0;
    step(); checks++; if (valid !== 1'b0) begin errs++; $error("FAIL valid_c1: observed=%0d", valid); end
    step(); checks++; if (valid !== 1'b0) begin errs++; $error("FAIL valid_c2: observed=%0d", valid); end
    step(); checks++; if (valid !== 1'b0) begin errs++; $error("FAIL valid_c3: observed=%0d", valid); end
    step(); checks++; if (valid !== 1'b1) begin errs++; $error("FAIL valid_c4: observed=%0d", valid); end
    checks++; if (mean !== 16'd0) begin errs++; $error("FAIL first_mean: observed=%0d", mean); end
`ifdef NHC_SLEW_LIMIT_EN
    checks++; if (dop !== 8'd144) begin errs++; $error("FAIL first_dop: observed=%0d", dop); end
`else
    checks++; if (dop !== 8'd255) begin errs++; $error("FAIL first_dop: observed=%0d", dop); end
`endif
    step(); checks++; if (valid !== 1'b0) begin errs++; $error("FAIL valid_c5: observed=%0d", valid); end
`ifdef NHC_SLEW_LIMIT_EN
    for (int k = 1; k <= 8; k++) begin
      int e;
      e = (144 + 16 * k > 255) ? 255 : 144 + 16 * k;
      wait_pulses(1);
      checks++; if (dop !== 8'(e)) begin errs++; $error("FAIL slew_seq: observed=%0d expected=%0d", dop, e); end
    end
`else
    wait_pulses(1);
    checks++; if (dop !== 8'd255) begin errs++; $error("FAIL sat_hold: observed=%0d", dop); end
`endif

    step();
    #2 rst = 1'b1;
    #1;
    checks++; if (dop !== 8'd128) begin errs++; $error("FAIL arst_dop: observed=%0d", dop); end
    checks++; if (mean !== 16'd0) begin errs++; $error("FAIL arst_mean: observed=%0d", mean); end
    checks++; if (valid !== 1'b0) begin errs++; $error("FAIL arst_valid: observed=%0d", valid); end
    checks++; if (dbg !== 32'd0) begin errs++; $error("FAIL arst_dbg: observed=%0d", dbg); end
    @(negedge clk) rst = 1'b0;

    alpha = 8'd32; spike_in = 8'hFF;
    step();
    alpha = 8'd0; spike_in = 8'h00;
    checks++; if (rate_bus[7] !== 16'd8192) begin errs++; $error("FAIL rate7_8192: observed=%0d", rate_bus[7]); end
    checks++; if (rate_bus[0] !== 16'd8192) begin errs++; $error("FAIL rate0_8192: observed=%0d", rate_bus[0]); end
    kp = 4'd5;
    wait_pulses(12);
    checks++; if (mean !== 16'd8192) begin errs++; $error("FAIL hi_mean: observed=%0d", mean); end
    checks++; if (dop !== 8'd0) begin errs++; $error("FAIL hi_dop_0: observed=%0d", dop); end
    da_min = 8'd32;
    wait_pulses(3);
    checks++; if (dop !== 8'd32) begin errs++; $error("FAIL clamp_min: observed=%0d", dop); end
    da_min = 8'd200; da_max = 8'd100;
    wait_pulses(2);
    checks++; if (dop !== 8'd200) begin errs++; $error("FAIL clamp_cross: observed=%0d", dop); end

    da_min = 8'd0; da_max = 8'd255; target = 16'd8292; hyst = 16'd256;
    for (int i = 0; i < 5; i++) begin
      wait_pulses(1);
      checks++; if (dop !== 8'd200) begin errs++; $error("FAIL deadband_hold: observed=%0d", dop); end
    end
    checks++; if (mean !== 16'd8192) begin errs++; $error("FAIL deadband_mean: observed=%0d", mean); end
    hyst = 16'd100;
    wait_pulses(1);
    checks++; if (dop !== 8'd200) begin errs++; $error("FAIL deadband_edge: observed=%0d", dop); end
    hyst = 16'd99;
    wait_pulses(6);
    checks++; if (dop !== 8'd131) begin errs++; $error("FAIL err_pos_100: observed=%0d", dop); end
    target = 16'd8092;
    wait_pulses(3);
    checks++; if (dop !== 8'd124) begin errs++; $error("FAIL err_neg_100: observed=%0d", dop); end

    alpha = 8'd32; spike_in = 8'h0F;
    step();
    alpha = 8'd0; spike_in = 8'h00;
    checks++; if (rate_bus[0] !== 16'd15360) begin errs++; $error("FAIL rate0_15360: observed=%0d", rate_bus[0]); end
    checks++; if (rate_bus[5] !== 16'd7168) begin errs++; $error("FAIL rate5_7168: observed=%0d", rate_bus[5]); end
    wait_pulses(3);
    checks++; if (mean !== 16'd11264) begin errs++; $error("FAIL mixed_mean: observed=%0d", mean); end
    wait_pulses(8);
    checks++; if (dop !== 8'd28) begin errs++; $error("FAIL mixed_dop: observed=%0d", dop); end

    wait_pulses(1);
    clk_en = 1'b0;
    #1;
    checks++; if (valid !== 1'b0) begin errs++; $error("FAIL valid_forced0: observed=%0d", valid); end
    alpha = 8'd32; spike_in = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (valid !== 1'b0) begin errs++; $error("FAIL frozen_valid: observed=%0d", valid); end
    end
    checks++; if (rate_bus[0] !== 16'd15360) begin errs++; $error("FAIL frozen_rate0: observed=%0d", rate_bus[0]); end
    checks++; if (rate_bus[5] !== 16'd7168) begin errs++; $error("FAIL frozen_rate5: observed=%0d", rate_bus[5]); end
    alpha = 8'd0; spike_in = 8'h00; clk_en = 1'b1;
    step(); checks++; if (valid !== 1'b0) begin errs++; $error("FAIL resume_c1: observed=%0d", valid); end
    step(); checks++; if (valid !== 1'b0) begin errs++; $error("FAIL resume_c2: observed=%0d", valid); end
    step(); checks++; if (valid !== 1'b0) begin errs++; $error("FAIL resume_c3: observed=%0d", valid); end
    step(); checks++; if (valid !== 1'b1) begin errs++; $error("FAIL resume_c4: observed=%0d", valid); end
    checks++; if (mean !== 16'd11264) begin errs++; $error("FAIL resume_mean: observed=%0d", mean); end
    checks++; if (dop !== 8'd28) begin errs++; $error("FAIL resume_dop: observed=%0d", dop); end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
